// File: rtl/hazard_ctrl.sv
// Hazard/stall/flush controller with debug run/halt/step FSM for a 5-stage pipeline.
// Optional stall-cycle counter is built only when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NB_REG-1:0] i_id_rs_num,
  input  logic [NB_REG-1:0] i_id_rt_num,
  input  logic              i_id_uses_rt,
  input  logic              i_id_is_brh,
  input  logic [NB_REG-1:0] i_id_dst_num,
  input  logic              i_id_wr_en,
  input  logic              i_id_is_load,
  input  logic              i_flush,
  input  logic              i_dbg_halt,
  input  logic              i_dbg_run,
  input  logic              i_dbg_step,
  input  logic              i_cnt_clr,
  output logic              o_pc_enb,
  output logic              o_if_id_enb,
  output logic              o_pipe_enb,
  output logic              o_id_ex_bubble,
  output logic              o_if_id_flush,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ex_vld_q, ex_vld_d;
  logic              ex_load_q, ex_load_d;
  logic [NB_REG-1:0] ex_dst_q, ex_dst_d;
  logic              mem_vld_q, mem_vld_d;
  logic              mem_load_q, mem_load_d;
  logic [NB_REG-1:0] mem_dst_q, mem_dst_d;

  logic match_ex_s;
  logic match_mem_s;
  logic stall_s;
  logic advance_s;

  // Dependency detection; slots never hold register 0 as valid, so r0 cannot match.
  always_comb begin
    match_ex_s  = ex_vld_q & ((ex_dst_q == i_id_rs_num) |
                              (i_id_uses_rt & (ex_dst_q == i_id_rt_num)));
    match_mem_s = mem_vld_q & ((mem_dst_q == i_id_rs_num) |
                               (i_id_uses_rt & (mem_dst_q == i_id_rt_num)));
    stall_s     = (match_ex_s & ex_load_q) |
                  (i_id_is_brh & match_ex_s) |
                  (i_id_is_brh & match_mem_s & mem_load_q);
    advance_s   = (state_q == ST_RUN) | (state_q == ST_STEP);
  end

  // Debug FSM next state; RUN has priority over STEP when both are asserted in HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_dbg_halt) state_d = ST_HALT;
        else            state_d = ST_RUN;
      end
      ST_HALT: begin
        if (i_dbg_run)       state_d = ST_RUN;
        else if (i_dbg_step) state_d = ST_STEP;
        else                 state_d = ST_HALT;
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // Shadow pipeline: a stalled ID instruction enters EX as a bubble.
  always_comb begin
    if (advance_s) begin
      ex_vld_d   = i_id_wr_en & ~stall_s & (i_id_dst_num != {NB_REG{1'b0}});
      ex_dst_d   = i_id_dst_num;
      ex_load_d  = i_id_is_load;
      mem_vld_d  = ex_vld_q;
      mem_dst_d  = ex_dst_q;
      mem_load_d = ex_load_q;
    end else begin
      ex_vld_d   = ex_vld_q;
      ex_dst_d   = ex_dst_q;
      ex_load_d  = ex_load_q;
      mem_vld_d  = mem_vld_q;
      mem_dst_d  = mem_dst_q;
      mem_load_d = mem_load_q;
    end
  end

  // State and shadow registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      ex_vld_q   <= 1'b0;
      ex_dst_q   <= {NB_REG{1'b0}};
      ex_load_q  <= 1'b0;
      mem_vld_q  <= 1'b0;
      mem_dst_q  <= {NB_REG{1'b0}};
      mem_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_vld_q   <= ex_vld_d;
      ex_dst_q   <= ex_dst_d;
      ex_load_q  <= ex_load_d;
      mem_vld_q  <= mem_vld_d;
      mem_dst_q  <= mem_dst_d;
      mem_load_q <= mem_load_d;
    end
  end

  // Pipeline controls; while reset is held everything is frozen and ID/EX gets a NOP.
  always_comb begin
    if (i_rst) begin
      o_pc_enb       = 1'b0;
      o_if_id_enb    = 1'b0;
      o_pipe_enb     = 1'b0;
      o_id_ex_bubble = 1'b1;
      o_if_id_flush  = 1'b0;
    end else begin
      o_pc_enb       = advance_s & ~stall_s;
      o_if_id_enb    = advance_s & ~stall_s;
      o_pipe_enb     = advance_s;
      o_id_ex_bubble = stall_s;
      o_if_id_flush  = i_flush & advance_s & ~stall_s;
    end
    o_halted = (state_q == ST_HALT);
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    if (i_cnt_clr) begin
      cnt_d = {NB_CNT{1'b0}};
    end else if (advance_s & stall_s & (cnt_q != {NB_CNT{1'b1}})) begin
      cnt_d = cnt_q + {{(NB_CNT-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= {NB_CNT{1'b0}};
    else       cnt_q <= cnt_d;
  end

  assign o_stall_cnt = cnt_q;
`else
  logic cnt_clr_unused_s;
  assign cnt_clr_unused_s = i_cnt_clr;
  assign o_stall_cnt      = {NB_CNT{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle stimulus tables, expected control vectors
// and stall-counter model pushed to a queue and compared at the falling edge.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       brh;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       halt;
    logic       run;
    logic       step;
    logic       clr;
  } stim_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [4:0]  i_id_rs_num = 5'd0, i_id_rt_num = 5'd0, i_id_dst_num = 5'd0;
  logic        i_id_uses_rt = 1'b0, i_id_is_brh = 1'b0, i_id_wr_en = 1'b0, i_id_is_load = 1'b0;
  logic        i_flush = 1'b0, i_dbg_halt = 1'b0, i_dbg_run = 1'b0, i_dbg_step = 1'b0;
  logic        i_cnt_clr = 1'b0;
  logic        o_pc_enb, o_if_id_enb, o_pipe_enb, o_id_ex_bubble, o_if_id_flush, o_halted;
  logic [31:0] o_stall_cnt;
  logic [5:0]  outs_s;

  logic [37:0] sb[$];
  logic [31:0] cnt_model = 32'd0;
  int          n_cmp = 0;
  int          n_err = 0;

  hazard_ctrl #(.NB_REG(5), .NB_CNT(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs_num(i_id_rs_num), .i_id_rt_num(i_id_rt_num),
    .i_id_uses_rt(i_id_uses_rt), .i_id_is_brh(i_id_is_brh),
    .i_id_dst_num(i_id_dst_num), .i_id_wr_en(i_id_wr_en), .i_id_is_load(i_id_is_load),
    .i_flush(i_flush), .i_dbg_halt(i_dbg_halt), .i_dbg_run(i_dbg_run),
    .i_dbg_step(i_dbg_step), .i_cnt_clr(i_cnt_clr),
    .o_pc_enb(o_pc_enb), .o_if_id_enb(o_if_id_enb), .o_pipe_enb(o_pipe_enb),
    .o_id_ex_bubble(o_id_ex_bubble), .o_if_id_flush(o_if_id_flush),
    .o_halted(o_halted), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  assign outs_s = {o_pc_enb, o_if_id_enb, o_pipe_enb, o_id_ex_bubble, o_if_id_flush, o_halted};

  // Expected vector bit order: {pc, if_id, pipe, bubble, flush, halted}
  localparam logic [5:0] E_RUN   = 6'b111000;
  localparam logic [5:0] E_STALL = 6'b001100;
  localparam logic [5:0] E_HALT  = 6'b000001;
  localparam logic [5:0] E_HSTL  = 6'b000101;
  localparam logic [5:0] E_RST   = 6'b000100;
  localparam logic [5:0] E_FLUSH = 6'b111010;

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                               input logic brh, input logic [4:0] dst, input logic wr,
                               input logic ld, input logic fl);
    stim_t s;
    s = '0;
    s.rs = rs; s.rt = rt; s.urt = urt; s.brh = brh;
    s.dst = dst; s.wr = wr; s.ld = ld; s.fl = fl;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    i_rst = s.rst; i_id_rs_num = s.rs; i_id_rt_num = s.rt; i_id_uses_rt = s.urt;
    i_id_is_brh = s.brh; i_id_dst_num = s.dst; i_id_wr_en = s.wr; i_id_is_load = s.ld;
    i_flush = s.fl; i_dbg_halt = s.halt; i_dbg_run = s.run; i_dbg_step = s.step;
    i_cnt_clr = s.clr;
  endtask

  // Push this cycle's expectation, then advance the counter model across the clock edge.
  task automatic push_exp(input logic [5:0] e, input stim_t s);
`ifdef HAZARD_STALL_CNT_EN
    sb.push_back({e, cnt_model});
`else
    sb.push_back({e, 32'd0});
`endif
    if (s.rst || s.clr) cnt_model = 32'd0;
    else if (e[3] && e[2] && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;
  endtask

  task automatic test_reset();
    stim_t s[$]; logic [5:0] e[$]; logic [37:0] exp;
    stim_t t;
    t = mk(5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1); t.rst = 1'b1;
    s.push_back(t); e.push_back(E_RST);
    t.halt = 1'b1;
    s.push_back(t); e.push_back(E_RST);
    t.halt = 1'b0;
    s.push_back(t); e.push_back(E_RST);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    foreach (s[i]) begin
      apply(s[i]); push_exp(e[i], s[i]);
      @(negedge i_clk);
      exp = sb.pop_front(); n_cmp++;
      if ({outs_s, o_stall_cnt} !== exp) begin
        n_err++;
        $display("FAIL reset[%0d]: got %b cnt %0d, want %b cnt %0d", i, outs_s, o_stall_cnt, exp[37:32], exp[31:0]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [5:0] e[$]; logic [37:0] exp;
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd2, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0)); e.push_back(E_STALL);
    s.push_back(mk(5'd2, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    foreach (s[i]) begin
      apply(s[i]); push_exp(e[i], s[i]);
      @(negedge i_clk);
      exp = sb.pop_front(); n_cmp++;
      if ({outs_s, o_stall_cnt} !== exp) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %b cnt %0d, want %b cnt %0d", i, outs_s, o_stall_cnt, exp[37:32], exp[31:0]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; logic [5:0] e[$]; logic [37:0] exp;
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_STALL);
    s.push_back(mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd8, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_STALL);
    s.push_back(mk(5'd8, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_STALL);
    s.push_back(mk(5'd8, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    foreach (s[i]) begin
      apply(s[i]); push_exp(e[i], s[i]);
      @(negedge i_clk);
      exp = sb.pop_front(); n_cmp++;
      if ({outs_s, o_stall_cnt} !== exp) begin
        n_err++;
        $display("FAIL branch[%0d]: got %b cnt %0d, want %b cnt %0d", i, outs_s, o_stall_cnt, exp[37:32], exp[31:0]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reg0_rt();
    stim_t s[$]; logic [5:0] e[$]; logic [37:0] exp;
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd1, 5'd5, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd1, 5'd5, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0)); e.push_back(E_STALL);
    s.push_back(mk(5'd1, 5'd5, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    foreach (s[i]) begin
      apply(s[i]); push_exp(e[i], s[i]);
      @(negedge i_clk);
      exp = sb.pop_front(); n_cmp++;
      if ({outs_s, o_stall_cnt} !== exp) begin
        n_err++;
        $display("FAIL reg0_rt[%0d]: got %b cnt %0d, want %b cnt %0d", i, outs_s, o_stall_cnt, exp[37:32], exp[31:0]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t s[$]; logic [5:0] e[$]; logic [37:0] exp;
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd3, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1)); e.push_back(E_STALL);
    s.push_back(mk(5'd3, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1)); e.push_back(E_FLUSH);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); e.push_back(E_RUN);
    foreach (s[i]) begin
      apply(s[i]); push_exp(e[i], s[i]);
      @(negedge i_clk);
      exp = sb.pop_front(); n_cmp++;
      if ({outs_s, o_stall_cnt} !== exp) begin
        n_err++;
        $display("FAIL flush[%0d]: got %b cnt %0d, want %b cnt %0d", i, outs_s, o_stall_cnt, exp[37:32], exp[31:0]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_debug();
    stim_t s[$]; logic [5:0] e[$]; logic [37:0] exp;
    stim_t nop, lw2, add2, t;
    nop  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    lw2  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    add2 = mk(5'd2, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    t = nop;  t.halt = 1'b1; s.push_back(t);    e.push_back(E_RUN);
    s.push_back(nop);                           e.push_back(E_HALT);
    t = nop;  t.step = 1'b1; s.push_back(t);    e.push_back(E_HALT);
    s.push_back(nop);                           e.push_back(E_RUN);
    s.push_back(nop);                           e.push_back(E_HALT);
    t = lw2;  t.step = 1'b1; s.push_back(t);    e.push_back(E_HALT);
    s.push_back(lw2);                           e.push_back(E_RUN);
    t = add2; t.step = 1'b1; s.push_back(t);    e.push_back(E_HSTL);
    s.push_back(add2);                          e.push_back(E_STALL);
    t = add2; t.run = 1'b1;  s.push_back(t);    e.push_back(E_HALT);
    s.push_back(add2);                          e.push_back(E_RUN);
    t = nop;  t.halt = 1'b1; s.push_back(t);    e.push_back(E_RUN);
    t = nop;  t.step = 1'b1; s.push_back(t);    e.push_back(E_HALT);
    t = nop;  t.rst = 1'b1;  s.push_back(t);    e.push_back(E_RST);
    s.push_back(nop);                           e.push_back(E_RUN);
    t = nop;  t.halt = 1'b1; s.push_back(t);    e.push_back(E_RUN);
    t = nop;  t.run = 1'b1; t.step = 1'b1; s.push_back(t); e.push_back(E_HALT);
    s.push_back(nop);                           e.push_back(E_RUN);
    s.push_back(nop);                           e.push_back(E_RUN);
    foreach (s[i]) begin
      apply(s[i]); push_exp(e[i], s[i]);
      @(negedge i_clk);
      exp = sb.pop_front(); n_cmp++;
      if ({outs_s, o_stall_cnt} !== exp) begin
        n_err++;
        $display("FAIL debug[%0d]: got %b cnt %0d, want %b cnt %0d", i, outs_s, o_stall_cnt, exp[37:32], exp[31:0]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_stall_cnt();
    stim_t s[$]; logic [5:0] e[$]; logic [37:0] exp;
    stim_t nop, lw2, add2, t;
    nop  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    lw2  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    add2 = mk(5'd2, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    t = nop; t.clr = 1'b1; s.push_back(t); e.push_back(E_RUN);
    for (int k = 0; k < 3; k++) begin
      s.push_back(lw2);  e.push_back(E_RUN);
      s.push_back(add2); e.push_back(E_STALL);
      s.push_back(add2); e.push_back(E_RUN);
    end
    s.push_back(nop);                          e.push_back(E_RUN);
    t = nop; t.clr = 1'b1; s.push_back(t);     e.push_back(E_RUN);
    s.push_back(nop);                          e.push_back(E_RUN);
    t = lw2;  t.halt = 1'b1; s.push_back(t);   e.push_back(E_RUN);
    s.push_back(add2);                         e.push_back(E_HSTL);
    t = add2; t.run = 1'b1;  s.push_back(t);   e.push_back(E_HSTL);
    s.push_back(add2);                         e.push_back(E_STALL);
    s.push_back(add2);                         e.push_back(E_RUN);
    s.push_back(nop);                          e.push_back(E_RUN);
    s.push_back(nop);                          e.push_back(E_RUN);
    foreach (s[i]) begin
      apply(s[i]); push_exp(e[i], s[i]);
      @(negedge i_clk);
      exp = sb.pop_front(); n_cmp++;
      if ({outs_s, o_stall_cnt} !== exp) begin
        n_err++;
        $display("FAIL stall_cnt[%0d]: got %b cnt %0d, want %b cnt %0d", i, outs_s, o_stall_cnt, exp[37:32], exp[31:0]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_reg0_rt();
    test_flush();
    test_debug();
    test_stall_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
